// File: rtl/rtl_dma32_pkg.sv
// Shared types and constants for the 32-bit DMA copy controller.
package rtl_dma32_pkg;

    localparam int         DMA_W         = 32;
    localparam logic [2:0] DMA_SIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_DATA = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Burst length for the next chunk: the words still to copy, capped at chunk.
    function automatic logic [8:0] chunk_len(input logic [31:0] remaining, input int chunk);
        if (remaining >= 32'(chunk)) begin
            return 9'(chunk);
        end
        return remaining[8:0];
    endfunction

endpackage

// File: rtl/rtl_dma32_fifo.sv
// Single-clock first-word-fall-through FIFO staging one DMA chunk.
module rtl_dma32_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;

    // Pointer update; reset empties the FIFO without touching storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Storage write; no reset so the array maps onto plain memory.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign head  = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/rtl_dma32_copy_ctrl.sv
// DMA sequencer: copies size words from index 0 to index size in chunks.
module rtl_dma32_copy_ctrl
    import rtl_dma32_pkg::*;
#(
    parameter int CHUNK = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] conf_info_size,
    input  logic        conf_done,
    output logic        dma_read_ctrl_valid,
    input  logic        dma_read_ctrl_ready,
    output logic [31:0] dma_read_ctrl_data_index,
    output logic [31:0] dma_read_ctrl_data_length,
    output logic [2:0]  dma_read_ctrl_data_size,
    input  logic        dma_read_chnl_valid,
    output logic        dma_read_chnl_ready,
    input  logic [31:0] dma_read_chnl_data,
    output logic        dma_write_ctrl_valid,
    input  logic        dma_write_ctrl_ready,
    output logic [31:0] dma_write_ctrl_data_index,
    output logic [31:0] dma_write_ctrl_data_length,
    output logic [2:0]  dma_write_ctrl_data_size,
    output logic        dma_write_chnl_valid,
    input  logic        dma_write_chnl_ready,
    output logic [31:0] dma_write_chnl_data,
    output logic        acc_done,
    output logic [31:0] debug
);
    state_t      state_reg, state_next;
    logic        conf_d_reg, conf_dd_reg;
    logic [31:0] size_reg, offset_reg, debug_reg;
    logic [8:0]  rd_cnt_reg, wr_cnt_reg;
    logic [8:0]  len;
    logic        start_edge;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [31:0] fifo_head;

    assign start_edge = conf_d_reg && !conf_dd_reg;
    assign len        = chunk_len(size_reg - offset_reg, CHUNK);
    assign fifo_push  = dma_read_chnl_valid && dma_read_chnl_ready;
    assign fifo_pop   = dma_write_chnl_valid && dma_write_chnl_ready;

    rtl_dma32_fifo #(.WIDTH(DMA_W), .DEPTH(CHUNK)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (dma_read_chnl_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_next           = state_reg;
        dma_read_ctrl_valid  = 1'b0;
        dma_read_chnl_ready  = 1'b0;
        dma_write_ctrl_valid = 1'b0;
        dma_write_chnl_valid = 1'b0;
        acc_done             = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_edge) begin
                    state_next = (conf_info_size == 32'd0) ? DONE : RD_REQ;
                end
            end
            RD_REQ: begin
                dma_read_ctrl_valid = 1'b1;
                if (dma_read_ctrl_ready) state_next = RD_DATA;
            end
            RD_DATA: begin
                dma_read_chnl_ready = (rd_cnt_reg < len) && !fifo_full;
                if (rd_cnt_reg == len) state_next = WR_REQ;
            end
            WR_REQ: begin
                dma_write_ctrl_valid = 1'b1;
                if (dma_write_ctrl_ready) state_next = WR_DATA;
            end
            WR_DATA: begin
                dma_write_chnl_valid = !fifo_empty && (wr_cnt_reg < len);
                if (wr_cnt_reg == len) begin
                    state_next = (offset_reg + {23'd0, len} == size_reg) ? DONE : RD_REQ;
                end
            end
            DONE: begin
                acc_done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Run bookkeeping: start detection, offsets, beat counters and word count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conf_d_reg  <= 1'b0;
            conf_dd_reg <= 1'b0;
            size_reg    <= '0;
            offset_reg  <= '0;
            debug_reg   <= '0;
            rd_cnt_reg  <= '0;
            wr_cnt_reg  <= '0;
        end else begin
            conf_d_reg  <= conf_done;
            conf_dd_reg <= conf_d_reg;
            if (state_reg == IDLE && start_edge) begin
                size_reg   <= conf_info_size;
                offset_reg <= '0;
                debug_reg  <= '0;
            end
            if (state_reg == RD_REQ) begin
                rd_cnt_reg <= '0;
                wr_cnt_reg <= '0;
            end
            if (fifo_push) rd_cnt_reg <= rd_cnt_reg + 1'b1;
            if (fifo_pop) begin
                wr_cnt_reg <= wr_cnt_reg + 1'b1;
                debug_reg  <= debug_reg + 1'b1;
            end
            if (state_reg == WR_DATA && wr_cnt_reg == len) begin
                offset_reg <= offset_reg + {23'd0, len};
            end
        end
    end

    // Index/length/data are forced to zero whenever their valid is low.
    assign dma_read_ctrl_data_index   = dma_read_ctrl_valid  ? offset_reg : 32'd0;
    assign dma_read_ctrl_data_length  = dma_read_ctrl_valid  ? {23'd0, len} : 32'd0;
    assign dma_write_ctrl_data_index  = dma_write_ctrl_valid ? (size_reg + offset_reg) : 32'd0;
    assign dma_write_ctrl_data_length = dma_write_ctrl_valid ? {23'd0, len} : 32'd0;
    assign dma_write_chnl_data        = dma_write_chnl_valid ? fifo_head : 32'd0;
    assign dma_read_ctrl_data_size    = DMA_SIZE_WORD;
    assign dma_write_ctrl_data_size   = DMA_SIZE_WORD;
    assign debug                      = debug_reg;

endmodule
